// File: rtl/example_sdiv_seq_21s_9ns.sv
// Sequential signed divider: 21-bit signed dividend by 9-bit unsigned divisor.
// Restoring division, one quotient bit per cycle, fixed 22-cycle latency with saturation.
module example_sdiv_seq_21s_9ns #(
    parameter logic [31:0] ID = 32'd1
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [20:0] dividend,
    input  logic [8:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [13:0] quotient,
    output logic [9:0]  remainder,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg;
    // Starts as |dividend|; quotient bits shift in from the LSB as dividend bits leave the MSB.
    logic [20:0] quo_reg;
    logic [8:0]  rem_reg;
    logic [8:0]  dsr_reg;
    logic        neg_reg;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic [13:0] quotient_reg;
    logic [9:0]  remainder_reg;
    logic        ovf_reg;

    logic        accept;
    logic [20:0] dividend_abs;
    logic [9:0]  trial;
    logic [9:0]  diff;
    logic        fits;
    logic [8:0]  rem_step;
    logic [13:0] fix_quo;
    logic [9:0]  fix_rem;
    logic        fix_ovf;

    assign accept       = in_valid && in_ready_reg;
    assign dividend_abs = dividend[20] ? (21'd0 - dividend) : dividend;

    assign trial    = {rem_reg, quo_reg[20]};
    assign diff     = trial - {1'b0, dsr_reg};
    assign fits     = (trial >= {1'b0, dsr_reg});
    assign rem_step = fits ? diff[8:0] : trial[8:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (cnt_reg == 5'd20) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sign application and saturation; a zero divisor leaves garbage in the datapath, so it is overridden here.
    always_comb begin
        fix_quo = 14'd0;
        fix_rem = 10'd0;
        fix_ovf = 1'b0;
        if (dsr_reg == 9'd0) begin
            fix_quo = neg_reg ? 14'h2000 : 14'h1fff;
            fix_ovf = 1'b1;
        end else begin
            fix_rem = neg_reg ? (10'd0 - {1'b0, rem_reg}) : {1'b0, rem_reg};
            if (neg_reg) begin
                if (quo_reg > 21'd8192) begin
                    fix_quo = 14'h2000;
                    fix_ovf = 1'b1;
                end else begin
                    fix_quo = 14'd0 - quo_reg[13:0];
                end
            end else begin
                if (quo_reg > 21'd8191) begin
                    fix_quo = 14'h1fff;
                    fix_ovf = 1'b1;
                end else begin
                    fix_quo = quo_reg[13:0];
                end
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 5'd0;
            quo_reg       <= 21'd0;
            rem_reg       <= 9'd0;
            dsr_reg       <= 9'd0;
            neg_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            quotient_reg  <= 14'd0;
            remainder_reg <= 10'd0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next == IDLE);
            out_valid_reg <= (state_next == DONE);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        quo_reg <= dividend_abs;
                        rem_reg <= 9'd0;
                        dsr_reg <= divisor;
                        neg_reg <= dividend[20];
                        cnt_reg <= 5'd0;
                    end
                end
                CALC: begin
                    quo_reg <= {quo_reg[19:0], fits};
                    rem_reg <= rem_step;
                    cnt_reg <= cnt_reg + 5'd1;
                end
                FIX: begin
                    quotient_reg  <= fix_quo;
                    remainder_reg <= fix_rem;
                    ovf_reg       <= fix_ovf;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign ovf       = ovf_reg;

endmodule
